scroll_background: RTL and testbench

//  Parametrised, horizontally scrolling background pixel generator for the VGA print path.
//  - Takes a per-pixel request (row/column) from the display scanner.
//  - Classifies the pixel as sky band, tiled ROM band, ground band or off-screen.
//  - Computes the tile-ROM address with a per-frame scroll offset and returns an RGB pixel

---
 rtl/scroll_background_pkg.sv | 20 ++
 rtl/bg_delay_line.sv | 25 ++
 rtl/bgd.sv | 26 ++
 rtl/scroll_background.sv | 153 +++++++++++++++
 tb/tb_scroll_background.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/scroll_background_pkg.sv
// Shared types and constants for the scrolling background generator.
// The pixel pipeline latency is derived here so the top and its users agree on it.
package bg_pkg;

  typedef enum logic [1:0] {
    REG_SKY    = 2'd0,
    REG_TILE   = 2'd1,
    REG_GROUND = 2'd2,
    REG_BLANK  = 2'd3
  } region_t;

  localparam logic [23:0] SKY_RGB_DEF    = 24'hEEFE91;
  localparam logic [23:0] GROUND_RGB_DEF = 24'h4EC0CA;

  // Request-to-pixel latency: address stage + ROM read + output stage.
  function automatic int unsigned lat_of(input int unsigned rom_lat);
    return rom_lat + 2;
  endfunction

endpackage

// File: rtl/bg_delay_line.sv
// Fixed-depth shift register used to carry {valid, region} alongside the ROM read.
module bg_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/bgd.sv
// Behavioural model of the bgd tile ROM core: synchronous read, LAT cycles from addr to data.
// Contents are a fixed hash of the address so every word is distinct and reproducible.
module bgd #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 24,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] rd [LAT];

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'((32'(a) * 32'h9E3779B1) ^ 32'(a));
  endfunction

  always_ff @(posedge clk) begin
    rd[0] <= rom_word(addr);
    for (int unsigned i = 1; i < LAT; i++) rd[i] <= rd[i-1];
  end

  assign data = rd[LAT-1];

endmodule

// File: rtl/scroll_background.sv
// Horizontally scrolling background pixel generator: classifies each requested pixel into
// a band, maps tile pixels through a scrolled ROM address, and returns RGB after a fixed latency.
module scroll_background
  import bg_pkg::*;
#(
  parameter int PIX_W         = 24,
  parameter int ROW_W         = 10,
  parameter int COL_W         = 10,
  parameter int ADDR_W        = 14,
  parameter int SCREEN_W      = 300,
  parameter int TILE_W        = 75,
  parameter int TILE_H        = 132,
  parameter int SKY_LAST      = 30,
  parameter int GROUND_FIRST  = 162,
  parameter int TILE_ROW_BASE = 161,
  parameter int SCROLL_STEP   = 1,
  parameter int ROM_LAT       = 1,
  parameter logic [PIX_W-1:0] SKY_RGB    = PIX_W'(SKY_RGB_DEF),
  parameter logic [PIX_W-1:0] GROUND_RGB = PIX_W'(GROUND_RGB_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_req,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic             frame_tick,
  input  logic             scroll_en,
  input  logic             scroll_clr,
  output logic [COL_W-1:0] scroll_ofs,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid
);

  localparam int unsigned MAX_K = (SCREEN_W + TILE_W + TILE_W - 1) / TILE_W;
  localparam int unsigned SUM_W = COL_W + 1;

  if (!(TILE_ROW_BASE - (SKY_LAST + 1) < TILE_H)) begin : g_chk_rows
    $error("tile band rows exceed TILE_H");
  end
  if (!(TILE_ROW_BASE >= GROUND_FIRST - 1)) begin : g_chk_base
    $error("TILE_ROW_BASE below last tile row");
  end
  if (!(TILE_W * TILE_H <= 2 ** ADDR_W)) begin : g_chk_addr
    $error("tile ROM does not fit ADDR_W");
  end
  if (!(ROM_LAT >= 1 && SCROLL_STEP > 0 && SCROLL_STEP < TILE_W)) begin : g_chk_misc
    $error("ROM_LAT or SCROLL_STEP out of range");
  end

  logic [COL_W-1:0]  ofs;
  logic [SUM_W-1:0]  ofs_sum;
  logic [SUM_W-1:0]  col_sum;
  logic [SUM_W-1:0]  tcol;
  region_t           region;
  logic              s1_valid;
  region_t           s1_region;
  logic [ADDR_W-1:0] s1_addr;
  logic [2:0]        dly_out;
  logic              d_valid;
  region_t           d_region;
  logic [PIX_W-1:0]  rom_data;
  logic [PIX_W-1:0]  pix_next;

  assign ofs_sum = {1'b0, ofs} + SUM_W'(SCROLL_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs <= '0;
    end else if (scroll_clr) begin
      ofs <= '0;
    end else if (frame_tick && scroll_en) begin
      ofs <= (ofs_sum >= SUM_W'(TILE_W)) ? COL_W'(ofs_sum - SUM_W'(TILE_W)) : COL_W'(ofs_sum);
    end
  end

  assign scroll_ofs = ofs;

  // Modulo by repeated compare: the largest k*TILE_W not above the sum wins.
  always_comb begin
    col_sum = {1'b0, req_col} + {1'b0, ofs};
    tcol    = col_sum;
    for (int unsigned k = 1; k <= MAX_K; k++) begin
      if (col_sum >= SUM_W'(k * TILE_W)) tcol = col_sum - SUM_W'(k * TILE_W);
    end
  end

  always_comb begin
    if (req_col >= COL_W'(SCREEN_W))          region = REG_BLANK;
    else if (req_row <= ROW_W'(SKY_LAST))     region = REG_SKY;
    else if (req_row >= ROW_W'(GROUND_FIRST)) region = REG_GROUND;
    else                                      region = REG_TILE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_region <= REG_SKY;
      s1_addr   <= '0;
    end else begin
      s1_valid <= pix_req;
      if (pix_req) begin
        s1_region <= region;
        s1_addr   <= (region == REG_TILE)
                   ? ADDR_W'(32'(TILE_ROW_BASE) - 32'(req_row) + 32'(tcol) * 32'(TILE_H))
                   : '0;
      end
    end
  end

  bgd #(
    .ADDR_W(ADDR_W),
    .DATA_W(PIX_W),
    .LAT   (ROM_LAT)
  ) u_rom (
    .clk (clk),
    .addr(s1_addr),
    .data(rom_data)
  );

  bg_delay_line #(
    .WIDTH(3),
    .DEPTH(ROM_LAT)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({s1_valid, s1_region}),
    .dout (dly_out)
  );

  assign d_valid  = dly_out[2];
  assign d_region = region_t'(dly_out[1:0]);

  always_comb begin
    pix_next = '0;
    case (d_region)
      REG_SKY:    pix_next = SKY_RGB;
      REG_GROUND: pix_next = GROUND_RGB;
      REG_TILE:   pix_next = rom_data;
      default:    pix_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= d_valid;
      if (d_valid) pix_out <= pix_next;
    end
  end

endmodule

// File: tb/tb_scroll_background.sv
// Scoreboard bench for scroll_background: two instances (ROM latency 1 and 2) share stimulus,
// expected pixels come from a band/modulo reference model and are checked at their due cycle.
module tb_scroll_background;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_req = 1'b0;
  logic [9:0] req_row = '0;
  logic [9:0] req_col = '0;
  logic       frame_tick = 1'b0;
  logic       scroll_en = 1'b0;
  logic       scroll_clr = 1'b0;

  logic [9:0]  ofs_a, ofs_b;
  logic [23:0] pix_a, pix_b;
  logic        val_a, val_b;

  always #5 clk = ~clk;

  scroll_background dut_a (
    .clk(clk), .rst_n(rst_n), .pix_req(pix_req), .req_row(req_row), .req_col(req_col),
    .frame_tick(frame_tick), .scroll_en(scroll_en), .scroll_clr(scroll_clr),
    .scroll_ofs(ofs_a), .pix_out(pix_a), .pix_valid(val_a)
  );

  scroll_background #(.ROM_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_req(pix_req), .req_row(req_row), .req_col(req_col),
    .frame_tick(frame_tick), .scroll_en(scroll_en), .scroll_clr(scroll_clr),
    .scroll_ofs(ofs_b), .pix_out(pix_b), .pix_valid(val_b)
  );

  typedef struct {
    logic [23:0] pix;
    int unsigned due;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          model_ofs = 0;
  logic [23:0] last_a = '0;
  logic [23:0] last_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] rom_word(input int unsigned a);
    int unsigned h;
    h = (a * 32'h9E3779B1) ^ a;
    return h[23:0];
  endfunction

  // Reference: band by row/column, tile pixel = ROM[(161-row) + ((col+ofs) mod 75)*132].
  function automatic logic [23:0] expected_pix(input int row, input int col, input int ofs);
    if (col >= 300) return 24'h0;
    if (row <= 30) return 24'hEEFE91;
    if (row >= 162) return 24'h4EC0CA;
    return rom_word(unsigned'((161 - row) + ((col + ofs) % 75) * 132) % 16384);
  endfunction

  task automatic step(input logic req, input int row, input int col,
                      input logic tick, input logic en, input logic clr);
    exp_t e;
    pix_req = req; req_row = 10'(row); req_col = 10'(col);
    frame_tick = tick; scroll_en = en; scroll_clr = clr;
    if (req && rst_n) begin
      e.pix = expected_pix(row, col, model_ofs);
      e.due = cyc + 3; q_a.push_back(e);
      e.due = cyc + 4; q_b.push_back(e);
    end
    @(posedge clk);
    if (!rst_n || clr) model_ofs = 0;
    else if (tick && en) model_ofs = (model_ofs + 1) % 75;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: each cycle, a due entry must be presented exactly now; otherwise valid stays low
  // and the last pixel is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_a = '0;
      last_b = '0;
    end
    if (q_a.size() > 0 && q_a[0].due == cyc) begin
      check("valid_a", 32'(val_a), 32'd1);
      check("pix_a", 32'(pix_a), 32'(q_a[0].pix));
      last_a = q_a[0].pix;
      void'(q_a.pop_front());
    end else begin
      check("idle_valid_a", 32'(val_a), 32'd0);
      check("hold_pix_a", 32'(pix_a), 32'(last_a));
    end
    if (q_b.size() > 0 && q_b[0].due == cyc) begin
      check("valid_b", 32'(val_b), 32'd1);
      check("pix_b", 32'(pix_b), 32'(q_b[0].pix));
      last_b = q_b[0].pix;
      void'(q_b.pop_front());
    end else begin
      check("idle_valid_b", 32'(val_b), 32'd0);
      check("hold_pix_b", 32'(pix_b), 32'(last_b));
    end
    check("ofs_a", 32'(ofs_a), 32'(model_ofs));
    check("ofs_b", 32'(ofs_b), 32'(model_ofs));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 10, 5, 1'b1, 1'b1, 1'b0);
      check("rst_pix", 32'(pix_a), 32'd0);
      check("rst_valid", 32'(val_a), 32'd0);
      check("rst_ofs", 32'(ofs_a), 32'd0);
    end
    rst_n = 1'b1;
    idle(3);

    // Bands and first tile address at offset 0
    step(1'b1, 10, 5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 200, 5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 100, 310, 1'b0, 1'b0, 1'b0);
    step(1'b1, 100, 80, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Offset wrap
    for (int i = 0; i < 74; i++) step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    check("ofs_at_74", 32'(ofs_a), 32'd74);
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    check("ofs_wrap", 32'(ofs_a), 32'd0);

    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 70; i++) step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 161, 10, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Freeze, request coincident with tick, clear beating tick
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    check("ofs_frozen", 32'(ofs_a), 32'd70);
    step(1'b1, 100, 20, 1'b1, 1'b1, 1'b0);
    step(1'b1, 100, 20, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    check("ofs_clr_prio", 32'(ofs_a), 32'd0);
    idle(5);

    // Streaming one full row, offset moving underneath
    for (int c = 0; c < 300; c++)
      step(1'b1, 100, c, 1'(($urandom % 16) == 0), 1'b1, 1'b0);
    idle(5);

    // Random mix
    for (int i = 0; i < 600; i++)
      step(1'(($urandom % 4) != 0), int'($urandom_range(0, 250)), int'($urandom_range(0, 340)),
           1'(($urandom % 6) == 0), 1'(($urandom % 4) != 0), 1'(($urandom % 64) == 0));

    // Mid-stream reset drops in-flight pixels
    step(1'b1, 100, 40, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10, 40, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    model_ofs = 0;
    step(1'b1, 100, 50, 1'b1, 1'b1, 1'b0);
    step(1'b1, 100, 51, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    idle(6);
    step(1'b1, 120, 299, 1'b1, 1'b1, 1'b0);
    step(1'b1, 31, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 161, 299, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 20 && (q_a.size() > 0 || q_b.size() > 0); i++) idle(1);
    check("drain_a", 32'(q_a.size()), 32'd0);
    check("drain_b", 32'(q_b.size()), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
